// File: rtl/alu_src2_stage.sv
// rtl/alu_src2_stage.sv - registered EX-stage ALU operand-2 selector with rs2 forwarding, load-use stall and 2-entry output buffer
// Optional: define SRC2_ERRCNT_EN to add the saturating err_cnt output.
module alu_src2_stage #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned FWD_N   = 2,
  parameter int unsigned STEP    = 4,
  parameter int unsigned SHAMT_W = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0]            rs2_addr,
  input  logic [XLEN-1:0]       rdata2,
  input  logic [XLEN-1:0]       imm_i,
  input  logic [XLEN-1:0]       imm_u,
  input  logic [XLEN-1:0]       imm_s,
  input  logic [6:0]            sel,
  input  logic [FWD_N-1:0]      fwd_valid,
  input  logic [FWD_N-1:0]      fwd_busy,
  input  logic [5*FWD_N-1:0]    fwd_addr,
  input  logic [XLEN*FWD_N-1:0] fwd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_data,
`ifdef SRC2_ERRCNT_EN
  output logic [7:0]            err_cnt,
`endif
  output logic                  out_sel_err
);

  localparam logic [XLEN-1:0] STEP_X = XLEN'(STEP);

  logic            hit;
  logic            hit_busy;
  logic [XLEN-1:0] rs2_eff;
  logic            need_rs2;
  logic            stall;
  logic [XLEN-1:0] sel_data;
  logic            sel_err;
  logic [XLEN-1:0] push_data;
  logic            push;
  logic            pop;

  logic [XLEN-1:0] mem_data [2];
  logic [1:0]      mem_err;
  logic            rd_ptr;
  logic            wr_ptr;
  logic [1:0]      count;

  // Resolve rs2: scan from the oldest port down so the youngest (lowest index) hit wins.
  always_comb begin
    hit      = 1'b0;
    hit_busy = 1'b0;
    rs2_eff  = rdata2;
    for (int i = int'(FWD_N) - 1; i >= 0; i--) begin
      if (fwd_valid[i] && (fwd_addr[5*i +: 5] == rs2_addr) && (rs2_addr != 5'd0)) begin
        hit      = 1'b1;
        hit_busy = fwd_busy[i];
        rs2_eff  = fwd_data[XLEN*i +: XLEN];
      end
    end
  end

  assign need_rs2 = sel[0] | sel[5] | sel[6];
  assign stall    = need_rs2 & hit & hit_busy;

  // AND-OR operand mux plus one-hot check; an illegal mode stores zero data.
  always_comb begin
    sel_data = '0;
    if (sel[0]) sel_data = sel_data | rs2_eff;
    if (sel[1]) sel_data = sel_data | imm_i;
    if (sel[2]) sel_data = sel_data | imm_u;
    if (sel[3]) sel_data = sel_data | STEP_X;
    if (sel[4]) sel_data = sel_data | imm_s;
    if (sel[5]) sel_data = sel_data | XLEN'(rs2_eff[31:0]);
    if (sel[6]) sel_data = sel_data | XLEN'(rs2_eff[SHAMT_W-1:0]);
    sel_err   = (sel == 7'd0) || ((sel & (sel - 7'd1)) != 7'd0);
    push_data = sel_err ? '0 : sel_data;
  end

  // in_ready depends only on buffer occupancy, the stall and flush, never on out_ready.
  assign in_ready    = (count != 2'd2) & ~stall & ~flush;
  assign push        = in_valid & in_ready;
  assign out_valid   = (count != 2'd0);
  assign pop         = out_valid & out_ready;
  assign out_data    = mem_data[rd_ptr];
  assign out_sel_err = mem_err[rd_ptr];

  // Two-entry ring buffer; flush empties it without touching the stored payloads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= 2'd0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      mem_data[0] <= '0;
      mem_data[1] <= '0;
      mem_err     <= 2'b00;
    end else if (flush) begin
      count  <= 2'd0;
      wr_ptr <= rd_ptr;
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= push_data;
        mem_err[wr_ptr]  <= sel_err;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef SRC2_ERRCNT_EN
  // Saturating count of accepted operations whose mode was not one-hot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 8'd0;
    end else if (push && sel_err && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_src2_stage.sv
// tb/tb_alu_src2_stage.sv - randomized self-checking bench for alu_src2_stage against a queue-based model
module tb_alu_src2_stage;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [4:0]   rs2_addr;
  logic [63:0]  rdata2;
  logic [63:0]  imm_i;
  logic [63:0]  imm_u;
  logic [63:0]  imm_s;
  logic [6:0]   sel;
  logic [1:0]   fwd_valid;
  logic [1:0]   fwd_busy;
  logic [9:0]   fwd_addr;
  logic [127:0] fwd_data;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_data;
  logic         out_sel_err;
`ifdef SRC2_ERRCNT_EN
  logic [7:0]   err_cnt;
`endif

  int total = 0;
  int bad   = 0;
  logic [64:0] q[$];
  int exp_ecnt = 0;

  alu_src2_stage #(.XLEN(64), .FWD_N(2), .STEP(4), .SHAMT_W(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .rs2_addr   (rs2_addr),
    .rdata2     (rdata2),
    .imm_i      (imm_i),
    .imm_u      (imm_u),
    .imm_s      (imm_s),
    .sel        (sel),
    .fwd_valid  (fwd_valid),
    .fwd_busy   (fwd_busy),
    .fwd_addr   (fwd_addr),
    .fwd_data   (fwd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
`ifdef SRC2_ERRCNT_EN
    .err_cnt    (err_cnt),
`endif
    .out_sel_err(out_sel_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model_rs2();
    logic [63:0] v;
    v = rdata2;
    if (rs2_addr != 5'd0) begin
      for (int p = 0; p < 2; p++) begin
        if (fwd_valid[p] && fwd_addr[5*p +: 5] == rs2_addr) begin
          v = fwd_data[64*p +: 64];
          break;
        end
      end
    end
    return v;
  endfunction

  function automatic bit model_stall();
    bit need;
    need = sel[0] | sel[5] | sel[6];
    if (rs2_addr == 5'd0) return 1'b0;
    for (int p = 0; p < 2; p++) begin
      if (fwd_valid[p] && fwd_addr[5*p +: 5] == rs2_addr) return need && fwd_busy[p];
    end
    return 1'b0;
  endfunction

  function automatic logic [64:0] model_entry();
    logic [63:0] r;
    r = model_rs2();
    if ($countones(sel) != 1) return {1'b1, 64'd0};
    case (sel)
      7'b0000001: return {1'b0, r};
      7'b0000010: return {1'b0, imm_i};
      7'b0000100: return {1'b0, imm_u};
      7'b0001000: return {1'b0, 64'd4};
      7'b0010000: return {1'b0, imm_s};
      7'b0100000: return {1'b0, 32'd0, r[31:0]};
      default:    return {1'b0, 58'd0, r[5:0]};
    endcase
  endfunction

  task automatic step();
    bit exp_rdy;
    bit acc;
    bit pop;
    logic [64:0] e;
    #1;
    exp_rdy = (q.size() < 2) && !model_stall() && !flush;
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("out_data", out_data, q[0][63:0]);
      chk("out_sel_err", out_sel_err, q[0][64]);
    end
`ifdef SRC2_ERRCNT_EN
    chk("err_cnt", err_cnt, exp_ecnt);
`endif
    acc = in_valid && exp_rdy;
    pop = (q.size() != 0) && out_ready;
    e   = model_entry();
    @(posedge clk);
    if (flush) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        q.push_back(e);
        if (e[64] && exp_ecnt < 255) exp_ecnt++;
      end
    end
    @(negedge clk);
  endtask

  task automatic head(input string name, input logic [63:0] d, input logic err);
    chk({name, "_valid"}, out_valid, 1'b1);
    chk({name, "_data"}, out_data, d);
    chk({name, "_err"}, out_sel_err, err);
  endtask

  task automatic clear_inputs();
    flush = 0; in_valid = 0; rs2_addr = 0; rdata2 = 0; imm_i = 0; imm_u = 0; imm_s = 0;
    sel = 0; fwd_valid = 0; fwd_busy = 0; fwd_addr = 0; fwd_data = 0; out_ready = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    q.delete();
    exp_ecnt = 0;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_data", out_data, 64'd0);
    chk("reset_out_sel_err", out_sel_err, 1'b0);
`ifdef SRC2_ERRCNT_EN
    chk("reset_err_cnt", err_cnt, 8'd0);
`endif
    rst_n = 1;
  endtask

  initial begin
    do_reset();

    // basic select
    out_ready = 1; in_valid = 1; sel = 7'b0001000;
    step();
    head("step4", 64'd4, 1'b0);
    sel = 7'b0100000; rdata2 = 64'hFFFF_FFFF_8000_0001;
    step();
    head("zext_w", 64'h0000_0000_8000_0001, 1'b0);
    sel = 7'b1000000; rdata2 = 64'hFF;
    step();
    head("shamt", 64'h3F, 1'b0);
    in_valid = 0;
    step();

    // forwarding priority
    in_valid = 1; sel = 7'b0000001; rs2_addr = 5'd5; rdata2 = 64'h1234;
    fwd_valid = 2'b11; fwd_busy = 2'b00; fwd_addr = {5'd5, 5'd5}; fwd_data = {64'hBB, 64'hAA};
    step();
    head("fwd_port0", 64'hAA, 1'b0);
    rs2_addr = 5'd0;
    step();
    head("fwd_x0", 64'h1234, 1'b0);
    in_valid = 0;
    step();

    // load-use stall
    rs2_addr = 5'd5; fwd_valid = 2'b01; fwd_busy = 2'b01; fwd_addr = {5'd0, 5'd5}; in_valid = 1; sel = 7'b0000001;
    for (int k = 0; k < 3; k++) begin
      #1 chk("stall_ready", in_ready, 1'b0);
      step();
    end
    fwd_busy = 2'b00;
    #1 chk("stall_release", in_ready, 1'b1);
    step();
    fwd_busy = 2'b01; sel = 7'b0000010; imm_i = 64'h77;
    #1 chk("stall_imm_ready", in_ready, 1'b1);
    step();
    in_valid = 0; fwd_valid = 0; fwd_busy = 0;
    repeat (2) step();

    // backpressure and full
    out_ready = 0; in_valid = 1; sel = 7'b0000001; rs2_addr = 5'd1;
    rdata2 = 64'hA; step();
    rdata2 = 64'hB; step();
    rdata2 = 64'hC;
    #1 chk("full_ready", in_ready, 1'b0);
    head("full_head", 64'hA, 1'b0);
    step(); step();
    head("held_head", 64'hA, 1'b0);
    out_ready = 1;
    #1 chk("full_ready_or", in_ready, 1'b0);
    step();
    head("order_b", 64'hB, 1'b0);
    step();
    in_valid = 0;
    head("order_c", 64'hC, 1'b0);
    repeat (2) step();

    // illegal sel
    do_reset();
    out_ready = 1; in_valid = 1; sel = 7'b0000000; rdata2 = 64'h55;
    step();
    head("sel_zero", 64'd0, 1'b1);
    sel = 7'b0000011; imm_i = 64'h99;
    step();
    head("sel_two", 64'd0, 1'b1);
    in_valid = 0;
    step();
`ifdef SRC2_ERRCNT_EN
    chk("err_cnt_two", err_cnt, 8'd2);
`endif
    in_valid = 1; sel = 7'b0000101;
    repeat (300) step();
    in_valid = 0;
    step();
`ifdef SRC2_ERRCNT_EN
    chk("err_cnt_sat", err_cnt, 8'd255);
`endif

    // flush at full with new input
    out_ready = 0; in_valid = 1; sel = 7'b0001000;
    step(); step();
    flush = 1;
    #1 chk("flush_ready", in_ready, 1'b0);
    step();
    flush = 0; in_valid = 0;
    chk("flush_valid", out_valid, 1'b0);
    step();

    // asynchronous reset mid-stream
    in_valid = 1; sel = 7'b0000010; imm_i = 64'hDEAD;
    step();
    in_valid = 0;
    #2 rst_n = 0;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_data", out_data, 64'd0);
    q.delete();
    exp_ecnt = 0;
    @(negedge clk);
    rst_n = 1;
    step();

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      rs2_addr  = 5'($urandom_range(0, 3));
      fwd_valid = 2'($urandom_range(0, 3));
      fwd_busy  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      fwd_addr  = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      fwd_data  = {$urandom, $urandom, $urandom, $urandom};
      rdata2    = {$urandom, $urandom};
      imm_i     = {$urandom, $urandom};
      imm_u     = {$urandom, $urandom};
      imm_s     = {$urandom, $urandom};
      sel       = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127)) : 7'(1 << $urandom_range(0, 6));
      flush     = ($urandom_range(0, 15) == 0);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
